// File: rtl/rst_sequencer_pkg.sv
// Shared types and sizing helper for the board-level reset sequencer.
package rst_sequencer_pkg;

  // Sequencer states; every 2-bit code is named, the default arm still
  // steers anything unexpected back to the MMCM reset pulse.
  typedef enum logic [1:0] {
    S_MMCM_RST  = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_RELEASE   = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  // Width of the single shared sequencing counter: enough for the largest
  // interval it has to measure, plus one bit of headroom.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/rst_sequencer_btn_debounce.sv
// Push-button conditioner: 2-FF synchroniser, stability counter and
// polarity normalisation. btn_db is active-high regardless of button wiring.
module btn_debounce #(
  parameter int   P_DEBOUNCE     = 100000,
  parameter logic P_BTN_POLARITY = 1'b1
) (
  input  logic i_sclk,
  input  logic i_arst_n,
  input  logic i_btn_rst,
  output logic btn_db
);

  localparam int             C_W    = $clog2(P_DEBOUNCE) + 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(P_DEBOUNCE - 1);
  localparam logic [C_W-1:0] C_ONE  = C_W'(1);

  logic           btn_meta_reg;
  logic           btn_sync_reg;
  logic           btn_act;
  logic           btn_db_reg;
  logic [C_W-1:0] stab_cnt_reg;

  // Bring the raw button into i_sclk; flops park at the released level.
  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      btn_meta_reg <= ~P_BTN_POLARITY;
      btn_sync_reg <= ~P_BTN_POLARITY;
    end else begin
      btn_meta_reg <= i_btn_rst;
      btn_sync_reg <= btn_meta_reg;
    end
  end

  assign btn_act = (btn_sync_reg == P_BTN_POLARITY);

  // Accept a change only after it has persisted for P_DEBOUNCE cycles;
  // any return to the accepted level restarts the count.
  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      btn_db_reg   <= 1'b0;
      stab_cnt_reg <= '0;
    end else if (btn_act != btn_db_reg) begin
      if (stab_cnt_reg == C_LAST) begin
        btn_db_reg   <= btn_act;
        stab_cnt_reg <= '0;
      end else begin
        stab_cnt_reg <= stab_cnt_reg + C_ONE;
      end
    end else begin
      stab_cnt_reg <= '0;
    end
  end

  assign btn_db = btn_db_reg;

endmodule

// File: rtl/rst_sequencer.sv
// Board-level reset sequencer: pulses the MMCM reset, waits for lock, then
// releases the domain resets one at a time. Button or lock loss restarts.
module rst_sequencer
  import rst_sequencer_pkg::*;
#(
  parameter int   P_NUM_OUT         = 3,
  parameter int   P_MMCM_RST_CYCLES = 16,
  parameter int   P_LOCK_TIMEOUT    = 65536,
  parameter int   P_STAGGER         = 16,
  parameter int   P_DEBOUNCE        = 100000,
  parameter logic P_BTN_POLARITY    = 1'b1,
  parameter logic P_OUT_POLARITY    = 1'b1
) (
  input  logic                 i_sclk,
  input  logic                 i_arst_n,
  input  logic                 i_btn_rst,
  input  logic                 i_locked,
  output logic                 o_mmcm_rst,
  output logic [P_NUM_OUT-1:0] o_rst,
  output logic                 o_ready,
  output logic [7:0]           o_fail_cnt
);

  localparam int               CNT_W       = cnt_width(P_MMCM_RST_CYCLES, P_LOCK_TIMEOUT,
                                                       P_STAGGER * P_NUM_OUT);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_MMCM_LAST = CNT_W'(P_MMCM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LOCK_LAST = CNT_W'(P_LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] C_REL_LAST  = CNT_W'(P_STAGGER * P_NUM_OUT - 1);

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [CNT_W-1:0]     cnt_next;
  logic [7:0]           fail_cnt_reg;
  logic [7:0]           fail_cnt_next;
  logic                 lock_meta_reg;
  logic                 lock_s;
  logic                 btn_db;
  logic                 abort;
  logic                 mmcm_act_next;
  logic                 ready_next;
  logic [P_NUM_OUT-1:0] rst_act_next;
  logic                 mmcm_rst_reg;
  logic [P_NUM_OUT-1:0] rst_reg;
  logic                 ready_reg;

  // Two-flop synchroniser for the MMCM lock indication.
  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      lock_meta_reg <= 1'b0;
      lock_s        <= 1'b0;
    end else begin
      lock_meta_reg <= i_locked;
      lock_s        <= lock_meta_reg;
    end
  end

  btn_debounce #(
    .P_DEBOUNCE     (P_DEBOUNCE),
    .P_BTN_POLARITY (P_BTN_POLARITY)
  ) u_btn_debounce (
    .i_sclk    (i_sclk),
    .i_arst_n  (i_arst_n),
    .i_btn_rst (i_btn_rst),
    .btn_db    (btn_db)
  );

  // Lock loss and button share one restart path once outputs are releasing.
  assign abort = !lock_s || btn_db;

  // State, counter, fail count and registered outputs.
  always_ff @(posedge i_sclk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_reg    <= S_MMCM_RST;
      cnt_reg      <= '0;
      fail_cnt_reg <= '0;
      mmcm_rst_reg <= P_OUT_POLARITY;
      rst_reg      <= {P_NUM_OUT{P_OUT_POLARITY}};
      ready_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      fail_cnt_reg <= fail_cnt_next;
      mmcm_rst_reg <= mmcm_act_next ~^ P_OUT_POLARITY;
      rst_reg      <= rst_act_next ~^ {P_NUM_OUT{P_OUT_POLARITY}};
      ready_reg    <= ready_next;
    end
  end

  // Next-state and counter decisions.
  always_comb begin
    state_next    = state_reg;
    cnt_next      = cnt_reg;
    fail_cnt_next = fail_cnt_reg;
    case (state_reg)
      S_MMCM_RST: begin
        if (btn_db) begin
          cnt_next = '0;
        end else if (cnt_reg == C_MMCM_LAST) begin
          state_next = S_WAIT_LOCK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      S_WAIT_LOCK: begin
        if (btn_db) begin
          state_next = S_MMCM_RST;
          cnt_next   = '0;
        end else if (lock_s) begin
          state_next = S_RELEASE;
          cnt_next   = '0;
        end else if (cnt_reg == C_LOCK_LAST) begin
          state_next    = S_MMCM_RST;
          cnt_next      = '0;
          fail_cnt_next = (fail_cnt_reg == 8'hFF) ? 8'hFF : fail_cnt_reg + 8'd1;
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      S_RELEASE: begin
        if (abort) begin
          state_next = S_MMCM_RST;
          cnt_next   = '0;
        end else if (cnt_reg == C_REL_LAST) begin
          state_next = S_RUN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + C_ONE;
        end
      end
      S_RUN: begin
        if (abort) begin
          state_next = S_MMCM_RST;
          cnt_next   = '0;
        end
      end
      default: begin
        state_next = S_MMCM_RST;
        cnt_next   = '0;
      end
    endcase
  end

  // Output decode from the upcoming state, ahead of the output registers.
  always_comb begin
    mmcm_act_next = (state_next == S_MMCM_RST);
    ready_next    = (state_next == S_RUN);
  end

  // Bit k stays released once the counter has passed its slot; outside
  // S_RELEASE/S_RUN every bit is held, so re-assertion is always all at once.
  genvar gi;
  generate
    for (gi = 0; gi < P_NUM_OUT; gi++) begin : g_rel
      localparam logic [CNT_W-1:0] C_THR = CNT_W'(P_STAGGER * (gi + 1));
      assign rst_act_next[gi] = !((state_next == S_RUN) ||
                                  ((state_next == S_RELEASE) && (cnt_next >= C_THR)));
    end
  endgenerate

  assign o_mmcm_rst = mmcm_rst_reg;
  assign o_rst      = rst_reg;
  assign o_ready    = ready_reg;
  assign o_fail_cnt = fail_cnt_reg;

endmodule
